// File: rtl/cnn_pkg.sv
// Shared constants and signed helper functions for the RGB conv / pooling pipeline.
// Helpers work on a 64-bit signed carrier so any channel width up to CALC_W can use them.
package cnn_pkg;

   localparam int CONV2_OUT_W    = 50;
   localparam int IMG_IN_SIZE    = 224;
   localparam int CONV1_OUT_SIZE = 222;
   localparam int CONV2_OUT_SIZE = 220;
   localparam int POOL_OUT_SIZE  = 110;

   localparam int CALC_W = 64;
   typedef logic signed [CALC_W-1:0] calc_t;

   function automatic calc_t smax(input calc_t a, input calc_t b);
      return (a > b) ? a : b;
   endfunction

   function automatic calc_t relu(input calc_t x);
      return (x < 0) ? '0 : x;
   endfunction

endpackage

// File: rtl/rgb_pool_linebuf.sv
// Simple dual-port line buffer holding one row of horizontal pair maxima.
// One write port, one registered read port; read data holds until the next read.
module rgb_pool_linebuf #(
   parameter int WIDTH = 150,
   parameter int DEPTH = 110,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: no reset on the array or read register, so the tools can map it onto block/distributed RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/rgb_relu_maxpool_2x2.sv
// Optional per-channel ReLU followed by 2x2 / stride-2 signed max-pooling of an RGB raster stream.
// Even rows park pair maxima in a line buffer; odd rows combine them with their own pair maxima.
module rgb_relu_maxpool_2x2
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = CONV2_OUT_W,
   parameter int IMAGE_W    = CONV2_OUT_SIZE,
   parameter int IMAGE_H    = CONV2_OUT_SIZE,
   parameter int RELU_EN    = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [3*DATA_WIDTH-1:0]   pix_in,
   input  logic                      pix_valid,
   output logic [3*DATA_WIDTH-1:0]   pool_out,
   output logic                      pool_valid,
   output logic                      row_last,
   output logic                      frame_done
);

   localparam int PW = 3 * DATA_WIDTH;
   localparam int CW = $clog2(IMAGE_W);
   localparam int RW = (IMAGE_H > 2) ? $clog2(IMAGE_H) : 1;
   localparam int AW = (CW > 1) ? CW - 1 : 1;

   if ((IMAGE_W % 2) != 0) begin : g_bad_w
      $error("rgb_relu_maxpool_2x2: IMAGE_W must be even");
   end
   if ((IMAGE_H % 2) != 0) begin : g_bad_h
      $error("rgb_relu_maxpool_2x2: IMAGE_H must be even");
   end
   if (DATA_WIDTH > CALC_W) begin : g_bad_dw
      $error("rgb_relu_maxpool_2x2: DATA_WIDTH exceeds CALC_W");
   end

   logic [CW-1:0] col_cnt;
   logic [RW-1:0] row_cnt;
   logic          col_odd, row_odd, col_end, row_end;
   logic [PW-1:0] act, pair_q, hmax, vmax, rd_data;
   logic          wr_en, rd_en;
   logic [AW-1:0] buf_addr;

   assign col_odd  = col_cnt[0];
   assign row_odd  = row_cnt[0];
   assign col_end  = (col_cnt == CW'(IMAGE_W - 1));
   assign row_end  = (row_cnt == RW'(IMAGE_H - 1));
   assign buf_addr = AW'(col_cnt >> 1);
   assign wr_en    = pix_valid & ~row_odd & col_odd;
   // Read issued on the even column so the data is ready when the odd column arrives.
   assign rd_en    = pix_valid & row_odd & ~col_odd;

   for (genvar ch = 0; ch < 3; ch++) begin : g_ch
      logic signed [DATA_WIDTH-1:0] x_in, x_act, pair_ch, rd_ch, hmax_ch;

      assign x_in    = pix_in[ch*DATA_WIDTH +: DATA_WIDTH];
      assign x_act   = (RELU_EN != 0) ? DATA_WIDTH'(relu(calc_t'(x_in))) : x_in;
      assign pair_ch = pair_q[ch*DATA_WIDTH +: DATA_WIDTH];
      assign rd_ch   = rd_data[ch*DATA_WIDTH +: DATA_WIDTH];
      assign hmax_ch = DATA_WIDTH'(smax(calc_t'(pair_ch), calc_t'(x_act)));

      assign act[ch*DATA_WIDTH +: DATA_WIDTH]  = x_act;
      assign hmax[ch*DATA_WIDTH +: DATA_WIDTH] = hmax_ch;
      assign vmax[ch*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(smax(calc_t'(rd_ch), calc_t'(hmax_ch)));
   end

   rgb_pool_linebuf #(
      .WIDTH (PW),
      .DEPTH (IMAGE_W / 2),
      .AW    (AW)
   ) u_linebuf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (buf_addr),
      .wr_data (hmax),
      .rd_en   (rd_en),
      .rd_addr (buf_addr),
      .rd_data (rd_data)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_cnt    <= '0;
         row_cnt    <= '0;
         pair_q     <= '0;
         pool_out   <= '0;
         pool_valid <= 1'b0;
         row_last   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         pool_valid <= 1'b0;
         row_last   <= 1'b0;
         frame_done <= 1'b0;
         if (pix_valid) begin
            if (col_end) begin
               col_cnt <= '0;
               row_cnt <= row_end ? '0 : row_cnt + 1'b1;
            end else begin
               col_cnt <= col_cnt + 1'b1;
            end

            if (!col_odd) pair_q <= act;

            if (row_odd && col_odd) begin
               pool_out   <= vmax;
               pool_valid <= 1'b1;
               row_last   <= col_end;
               frame_done <= col_end & row_end;
            end
         end
      end
   end

endmodule

// File: tb/tb_rgb_relu_maxpool_2x2.sv
// Directed and randomized bench for rgb_relu_maxpool_2x2: 4x4 frames (ReLU on/off) and one 220x220 frame.
// Expected outputs come from a window-max model over the stored input frame.
module tb_rgb_relu_maxpool_2x2;

   localparam int DW = 50;
   localparam int SW = 4;
   localparam int SH = 4;
   localparam int BW = 220;
   localparam int BH = 220;
   localparam int PW = 3 * DW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_s, rst_b, v_s, v_b;
   logic [PW-1:0] in_s, in_b;
   logic [PW-1:0] out_r, out_n, out_b;
   logic          pv_r, pv_n, pv_b, rl_r, rl_n, rl_b, fd_r, fd_n, fd_b;

   rgb_relu_maxpool_2x2 #(.DATA_WIDTH(DW), .IMAGE_W(SW), .IMAGE_H(SH), .RELU_EN(1)) u_relu (
      .clk(clk), .rst(rst_s), .pix_in(in_s), .pix_valid(v_s),
      .pool_out(out_r), .pool_valid(pv_r), .row_last(rl_r), .frame_done(fd_r));

   rgb_relu_maxpool_2x2 #(.DATA_WIDTH(DW), .IMAGE_W(SW), .IMAGE_H(SH), .RELU_EN(0)) u_norelu (
      .clk(clk), .rst(rst_s), .pix_in(in_s), .pix_valid(v_s),
      .pool_out(out_n), .pool_valid(pv_n), .row_last(rl_n), .frame_done(fd_n));

   rgb_relu_maxpool_2x2 u_big (
      .clk(clk), .rst(rst_b), .pix_in(in_b), .pix_valid(v_b),
      .pool_out(out_b), .pool_valid(pv_b), .row_last(rl_b), .frame_done(fd_b));

   int n_cmp = 0;
   int n_err = 0;

   longint        img [BW*BH][3];
   int            cur_w, cur_h;
   bit            big;
   int            n_strobe, n_rl, n_fd;
   longint        q_r[$], q_g[$];
   logic [PW-1:0] last_r, last_n, last_b;

   task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic longint act_ref(input longint x, input bit relu_on);
      return (relu_on && x < 0) ? 64'sd0 : x;
   endfunction

   // Max of the activated 2x2 window whose bottom-right pixel is (r,c).
   function automatic logic [PW-1:0] pool_exp(input int r, input int c, input bit relu_on);
      logic [PW-1:0] res;
      logic [63:0]   t;
      longint        m, x;
      res = '0;
      for (int ch = 0; ch < 3; ch++) begin
         m = act_ref(img[(r-1)*cur_w + c-1][ch], relu_on);
         for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
               x = act_ref(img[(r-1+dr)*cur_w + c-1+dc][ch], relu_on);
               if (x > m) m = x;
            end
         end
         t = m;
         res[ch*DW +: DW] = t[DW-1:0];
      end
      return res;
   endfunction

   function automatic logic [PW-1:0] pack_pix(input int idx);
      logic [PW-1:0] p;
      logic [63:0]   t;
      for (int ch = 0; ch < 3; ch++) begin
         t = img[idx][ch];
         p[ch*DW +: DW] = t[DW-1:0];
      end
      return p;
   endfunction

   // Present one beat (or an idle cycle), clock it, then check every observable output.
   task automatic step(input bit valid, input int r, input int c);
      logic [PW-1:0] pix;
      bit            prod, rl_e, fd_e;
      pix = valid ? pack_pix(r*cur_w + c) : '0;
      if (big) begin v_b = valid; in_b = pix; end
      else begin v_s = valid; in_s = pix; end
      @(posedge clk);
      #1;
      prod = valid && (r % 2 == 1) && (c % 2 == 1);
      rl_e = (c == cur_w - 1);
      fd_e = rl_e && (r == cur_h - 1);
      if (big) begin
         check("pool_valid_big", pv_b, prod);
         if (prod) begin
            last_b = pool_exp(r, c, 1'b1);
            check("row_last_big", rl_b, rl_e);
            check("frame_done_big", fd_b, fd_e);
         end
         check("pool_out_big", out_b, last_b);
         if (pv_b) begin
            n_strobe++;
            if (rl_b) n_rl++;
            if (fd_b) n_fd++;
         end
         v_b = 1'b0;
      end else begin
         check("pool_valid_relu", pv_r, prod);
         check("pool_valid_norelu", pv_n, prod);
         if (prod) begin
            last_r = pool_exp(r, c, 1'b1);
            last_n = pool_exp(r, c, 1'b0);
            check("row_last_relu", rl_r, rl_e);
            check("frame_done_relu", fd_r, fd_e);
            check("row_last_norelu", rl_n, rl_e);
            check("frame_done_norelu", fd_n, fd_e);
         end
         check("pool_out_relu", out_r, last_r);
         check("pool_out_norelu", out_n, last_n);
         if (pv_r) begin
            n_strobe++;
            if (rl_r) n_rl++;
            if (fd_r) n_fd++;
            q_r.push_back(longint'($signed(out_r[DW-1:0])));
            q_g.push_back(longint'($signed(out_n[2*DW-1:DW])));
         end
         v_s = 1'b0;
      end
   endtask

   task automatic send_frame(input bit gaps);
      for (int r = 0; r < cur_h; r++) begin
         for (int c = 0; c < cur_w; c++) begin
            if (gaps) repeat ($urandom_range(1, 3)) step(1'b0, 0, 0);
            step(1'b1, r, c);
         end
      end
   endtask

   task automatic fill_small(input longint offset);
      for (int i = 0; i < SW*SH; i++) begin
         img[i][0] = longint'(i) + offset;
         img[i][1] = -(longint'(i) + offset);
         img[i][2] = 100;
      end
   endtask

   task automatic clear_counts();
      n_strobe = 0; n_rl = 0; n_fd = 0;
      q_r.delete(); q_g.delete();
   endtask

   task automatic check_counts(input string tag, input int s, input int rl, input int fd);
      check({tag, "_strobes"}, n_strobe, s);
      check({tag, "_row_last"}, n_rl, rl);
      check({tag, "_frame_done"}, n_fd, fd);
   endtask

   initial begin
      longint        exp_r[4];
      longint        exp_g[4];
      logic [63:0]   raw;
      longint        v;

      exp_r = '{5, 7, 13, 15};
      exp_g = '{0, -2, -8, -10};
      rst_s = 1'b1; rst_b = 1'b1;
      v_s = 1'b0; v_b = 1'b0; in_s = '0; in_b = '0;
      last_r = '0; last_n = '0; last_b = '0;
      big = 1'b0; cur_w = SW; cur_h = SH;

      // Reset state of all three instances.
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_relu", out_r, '0);
      check("rst_valid_relu", pv_r, 1'b0);
      check("rst_rl_relu", rl_r, 1'b0);
      check("rst_fd_relu", fd_r, 1'b0);
      check("rst_out_norelu", out_n, '0);
      check("rst_valid_norelu", pv_n, 1'b0);
      check("rst_out_big", out_b, '0);
      check("rst_valid_big", pv_b, 1'b0);
      check("rst_rl_big", rl_b, 1'b0);
      check("rst_fd_big", fd_b, 1'b0);
      rst_s = 1'b0; rst_b = 1'b0;

      // Cases 1 and 2: continuous 4x4 frame, ReLU on and off in parallel.
      fill_small(0);
      clear_counts();
      send_frame(1'b0);
      check_counts("case1", 4, 2, 1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("case1_r%0d", i), q_r[i], exp_r[i]);
         check($sformatf("case2_g%0d", i), q_g[i], exp_g[i]);
      end

      // Case 3: random idle gaps between beats.
      clear_counts();
      send_frame(1'b1);
      check_counts("case3", 4, 2, 1);

      // Case 4: reset lands on the 6th beat of a partial frame.
      clear_counts();
      for (int i = 0; i < 5; i++) step(1'b1, i / SW, i % SW);
      v_s = 1'b1; in_s = pack_pix(5); rst_s = 1'b1;
      @(posedge clk);
      #1;
      v_s = 1'b0;
      check("case4_rst_valid", pv_r, 1'b0);
      check("case4_rst_out", out_r, '0);
      last_r = '0; last_n = '0;
      rst_s = 1'b0;
      send_frame(1'b0);
      check_counts("case4", 4, 2, 1);
      for (int i = 0; i < 4; i++) check($sformatf("case4_r%0d", i), q_r[i], exp_r[i]);

      // Case 5: two frames back-to-back, second offset by 1000.
      clear_counts();
      fill_small(0);
      send_frame(1'b0);
      fill_small(1000);
      send_frame(1'b0);
      check_counts("case5", 8, 4, 2);
      for (int i = 0; i < 4; i++) check($sformatf("case5_r%0d", i), q_r[4+i], exp_r[i] + 1000);

      // Case 6: default 220x220 frame of random signed 50-bit data.
      big = 1'b1; cur_w = BW; cur_h = BH;
      for (int i = 0; i < BW*BH; i++) begin
         for (int ch = 0; ch < 3; ch++) begin
            raw = {$urandom(), $urandom()};
            v = $signed(raw);
            img[i][ch] = (v <<< 14) >>> 14;
         end
      end
      clear_counts();
      send_frame(1'b0);
      check_counts("case6", 12100, 110, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
